vdiv_arbiter: RTL

VDIV_ARBITER -- requirements
Module: vdiv_arbiter

---
 rtl/vdiv_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vdiv_arbiter.sv
// vdiv_arbiter: two-requester round-robin front end for a vector divider.
// Grants one operation at a time, latches the winner's configuration and
// sequences IDLE -> LAUNCH -> RUN -> DONE around the divider's busy flag.
// Optional watchdog abort is compiled in with `define VDIV_ARB_TIMEOUT_EN.
module vdiv_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MVL        = 32,
    parameter int VLR_W      = 6,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req,
    input  logic [1:0]                 req_op_div,
    input  logic [1:0][1:0]            req_cont_esc,
    input  logic [1:0][DATA_WIDTH:0]   req_op_esc,
    input  logic [1:0][MVL-1:0]        req_mask,
    input  logic [1:0][VLR_W-1:0]      req_vlr,
    output logic [1:0]                 grant,
    output logic [1:0]                 done,
    output logic                       div_start,
    output logic                       div_op_div,
    output logic [1:0]                 div_cont_esc,
    output logic [DATA_WIDTH:0]        div_op_esc,
    output logic [MVL-1:0]             div_mask,
    output logic [VLR_W-1:0]           div_vlr,
    input  logic                       div_busy,
    output logic                       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t r_state;
    state_t w_next;
    logic   r_last;       // index of the requester served most recently
    logic   r_owner;      // requester that owns the in-flight operation
    logic   r_run_first;  // first RUN cycle: busy has not risen yet
    logic   w_win;
    logic   w_grant_v;
    logic   w_to;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        w_win = 1'b0;
        if (req == 2'b11) begin
            w_win = ~r_last;
        end else if (req[1]) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end

    assign w_grant_v = (r_state == ST_IDLE) && (req != 2'b00) && !div_busy;

`ifdef VDIV_ARB_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;

    // Watchdog counter: cleared in LAUNCH, counts every RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    assign w_to = (r_state == ST_RUN) && (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
    logic [TO_W-1:0] w_unused_to_limit;
    assign w_unused_to_limit = TO_W'(TIMEOUT - 1);
    assign w_to = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a zero-length request goes straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_v) begin
                    if (req_vlr[w_win] == {VLR_W{1'b0}}) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_LAUNCH;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LAUNCH: w_next = ST_RUN;
            ST_RUN: begin
                if (w_to) begin
                    w_next = ST_IDLE;
                end else if (!r_run_first && !div_busy) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state, owner and the live grant decision.
    always_comb begin
        grant     = 2'b00;
        done      = 2'b00;
        div_start = 1'b0;
        timeout   = w_to;
        if (w_grant_v) begin
            grant = w_win ? 2'b10 : 2'b01;
        end else begin
            grant = 2'b00;
        end
        if ((r_state == ST_DONE) || w_to) begin
            done = r_owner ? 2'b10 : 2'b01;
        end else begin
            done = 2'b00;
        end
        if (r_state == ST_LAUNCH) begin
            div_start = 1'b1;
        end else begin
            div_start = 1'b0;
        end
    end

    // Marks the first RUN cycle so busy is only trusted from the second.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_first <= 1'b0;
        end else begin
            r_run_first <= (r_state == ST_LAUNCH);
        end
    end

    // Capture winner configuration, owner and round-robin pointer at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            div_op_div   <= 1'b0;
            div_cont_esc <= 2'b00;
            div_op_esc   <= '0;
            div_mask     <= '0;
            div_vlr      <= '0;
        end else if (w_grant_v) begin
            r_last       <= w_win;
            r_owner      <= w_win;
            div_op_div   <= req_op_div[w_win];
            div_cont_esc <= req_cont_esc[w_win];
            div_op_esc   <= req_op_esc[w_win];
            div_mask     <= req_mask[w_win];
            div_vlr      <= req_vlr[w_win];
        end else begin
            r_last       <= r_last;
            r_owner      <= r_owner;
            div_op_div   <= div_op_div;
            div_cont_esc <= div_cont_esc;
            div_op_esc   <= div_op_esc;
            div_mask     <= div_mask;
            div_vlr      <= div_vlr;
        end
    end

endmodule
